// File: rtl/json_rx_pkg.sv
// Parser state and key codes for json_feedback_rx.
package json_rx_pkg;
    import lcd_inst_pkg::*;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_OPEN, S_KEY, S_KEY_CLOSE, S_COLON,
        S_VALUE, S_SCALE, S_WAIT_NL, S_COMMIT, S_ERROR
    } rx_state_e;

    typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R, KEY_X} key_e;

    function automatic key_e key_decode(input logic [7:0] c);
        case (c)
            CH_T:    return KEY_T;
            CH_L:    return KEY_L;
            CH_R:    return KEY_R;
            default: return KEY_X;
        endcase
    endfunction
endpackage

// File: rtl/lcd_inst_pkg.sv
// Shared ASCII character constants for the text-based UART/LCD front ends.
package lcd_inst_pkg;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_L      = 8'h4C;
    localparam logic [7:0] CH_R      = 8'h52;
    localparam logic [7:0] CH_T      = 8'h54;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, one-cycle valid pulse per good frame.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned BITS_N       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(BITS_N + 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

    uart_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [BITS_N-1:0] shift_q;
    logic              meta_q, rx_q, valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            meta_q  <= 1'b1;
            rx_q    <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            meta_q  <= rx;
            rx_q    <= meta_q;
            valid_q <= 1'b0;
            case (state_q)
                U_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_q) state_q <= U_START;
                end
                // Re-check the start bit half a bit in, then sample on whole-bit steps.
                U_START: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_q ? U_IDLE : U_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                U_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_q, shift_q[BITS_N-1:1]};
                        if (bit_q == BIT_W'(BITS_N - 1)) state_q <= U_STOP;
                        else bit_q <= bit_q + BIT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                U_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        valid_q <= rx_q;
                        state_q <= U_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= U_IDLE;
            endcase
        end
    end

    assign data_rx = shift_q;
    assign valid   = valid_q;
endmodule

// File: rtl/json_feedback_rx.sv
// Serial JSON feedback parser: {"T":..,"L":..,"R":..}\n -> T and fixed-point L/R.
// Define JSON_RX_ERRCNT_EN to add the err_count saturating parse-error counter.
module json_feedback_rx
    import lcd_inst_pkg::*, json_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 50_000_000 / 115_200,
    parameter int unsigned BITS_N        = 8,
    parameter int unsigned VAL_W         = 32,
    parameter int unsigned FRAC_DIGITS   = 3,
    parameter int unsigned MAX_VAL_CHARS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_in,
    output logic             msg_valid,
    output logic [VAL_W-1:0] t_code,
    output logic [VAL_W-1:0] l_val,
    output logic [VAL_W-1:0] r_val,
    output logic             l_present,
    output logic             r_present,
    output logic             parse_error,
    output logic             busy
`ifdef JSON_RX_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);
    localparam int unsigned ACC_W  = VAL_W + 4;
    localparam int unsigned CNT_W  = $clog2(MAX_VAL_CHARS + 2);
    localparam int unsigned FRAC_W = $clog2(FRAC_DIGITS + 2);
    localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'({(VAL_W-1){1'b1}});

    logic [BITS_N-1:0] rx_data;
    logic              rx_valid;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BITS_N(BITS_N)) u_rx (
        .clk(clk), .rst(rst), .rx(uart_in), .data_rx(rx_data), .valid(rx_valid)
    );

    rx_state_e         state_q;
    key_e              key_q;
    logic [7:0]        buf_q, term_q;
    logic              pend_q;
    logic [VAL_W-1:0]  acc_q, t_sh_q, l_sh_q, r_sh_q;
    logic              neg_q, dot_q, dig_q, t_seen_q, l_seen_q, r_seen_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FRAC_W-1:0] frac_q;
    logic              msg_valid_q, l_present_q, r_present_q, parse_error_q, busy_q;
    logic [VAL_W-1:0]  t_code_q, l_val_q, r_val_q;

    logic [7:0]        cur;
    logic              take, is_ws, is_digit, val_char, acc_take, scale_more, abort;
    logic [ACC_W-1:0]  digit, acc_mul, acc_d;
    logic [VAL_W-1:0]  val_c;

    // Byte classification and every abort condition, evaluated before the state update.
    always_comb begin
        cur        = pend_q ? buf_q : 8'(rx_data);
        take       = (pend_q || rx_valid) && (state_q != S_SCALE) && (state_q != S_COMMIT);
        is_ws      = (cur == CH_SP) || (cur == CH_CR);
        is_digit   = (cur >= CH_0) && (cur <= CH_9);
        digit      = ACC_W'(cur - CH_0);
        acc_mul    = ACC_W'(acc_q) * ACC_W'(10);
        acc_d      = acc_mul + digit;
        val_char   = is_digit || ((cur == CH_MINUS) && (cnt_q == '0)) || ((cur == CH_DOT) && !dot_q);
        acc_take   = !dot_q || (frac_q < FRAC_W'(FRAC_DIGITS));
        scale_more = (key_q != KEY_T) && (frac_q < FRAC_W'(FRAC_DIGITS));
        val_c      = neg_q ? VAL_W'(-acc_q) : acc_q;
        abort      = 1'b0;
        if (take && (state_q != S_IDLE) && (state_q != S_ERROR)) begin
            if (cur == CH_LBRACE) abort = 1'b1;
            if ((cur == CH_LF) && (state_q != S_WAIT_NL)) abort = 1'b1;
            case (state_q)
                S_KEY_OPEN, S_KEY_CLOSE: if (!is_ws && (cur != CH_QUOTE)) abort = 1'b1;
                S_COLON:                 if (!is_ws && (cur != CH_COLON)) abort = 1'b1;
                S_WAIT_NL:               if (!is_ws && (cur != CH_LF))    abort = 1'b1;
                S_VALUE: begin
                    if (val_char) begin
                        if (cnt_q == CNT_W'(MAX_VAL_CHARS))            abort = 1'b1;
                        if ((cur == CH_DOT) && (key_q == KEY_T))       abort = 1'b1;
                        if (is_digit && acc_take && (acc_d > MAG_MAX)) abort = 1'b1;
                    end else if (!dig_q) begin
                        abort = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (state_q == S_SCALE) begin
            if (scale_more) begin
                if (acc_mul > MAG_MAX) abort = 1'b1;
            end else if (term_q == CH_RBRACE) begin
                if (!t_seen_q && (key_q != KEY_T)) abort = 1'b1;
            end else if (term_q != CH_COMMA) begin
                abort = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            key_q         <= KEY_X;
            buf_q         <= '0;
            term_q        <= '0;
            pend_q        <= 1'b0;
            acc_q         <= '0;
            t_sh_q        <= '0;
            l_sh_q        <= '0;
            r_sh_q        <= '0;
            neg_q         <= 1'b0;
            dot_q         <= 1'b0;
            dig_q         <= 1'b0;
            t_seen_q      <= 1'b0;
            l_seen_q      <= 1'b0;
            r_seen_q      <= 1'b0;
            cnt_q         <= '0;
            frac_q        <= '0;
            msg_valid_q   <= 1'b0;
            t_code_q      <= '0;
            l_val_q       <= '0;
            r_val_q       <= '0;
            l_present_q   <= 1'b0;
            r_present_q   <= 1'b0;
            parse_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            msg_valid_q   <= 1'b0;
            parse_error_q <= 1'b0;
            // One-deep holding register keeps bytes that land while SCALE/COMMIT run.
            if (rx_valid && (!take || pend_q)) begin
                buf_q  <= 8'(rx_data);
                pend_q <= 1'b1;
            end else if (take) begin
                pend_q <= 1'b0;
            end

            if (abort) begin
                parse_error_q <= 1'b1;
                state_q       <= (take && (cur == CH_LF)) ? S_IDLE : S_ERROR;
                busy_q        <= !(take && (cur == CH_LF));
            end else begin
                case (state_q)
                    S_IDLE: if (take && (cur == CH_LBRACE)) begin
                        state_q  <= S_KEY_OPEN;
                        busy_q   <= 1'b1;
                        t_seen_q <= 1'b0;
                        l_seen_q <= 1'b0;
                        r_seen_q <= 1'b0;
                    end
                    S_KEY_OPEN:  if (take && (cur == CH_QUOTE)) state_q <= S_KEY;
                    S_KEY: if (take) begin
                        key_q   <= key_decode(cur);
                        state_q <= S_KEY_CLOSE;
                    end
                    S_KEY_CLOSE: if (take && (cur == CH_QUOTE)) state_q <= S_COLON;
                    S_COLON: if (take && (cur == CH_COLON)) begin
                        state_q <= S_VALUE;
                        acc_q   <= '0;
                        neg_q   <= 1'b0;
                        dot_q   <= 1'b0;
                        dig_q   <= 1'b0;
                        cnt_q   <= '0;
                        frac_q  <= '0;
                    end
                    S_VALUE: if (take) begin
                        if (val_char) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (is_digit) begin
                                dig_q <= 1'b1;
                                if (acc_take) begin
                                    acc_q <= VAL_W'(acc_d);
                                    if (dot_q) frac_q <= frac_q + FRAC_W'(1);
                                end
                            end else if (cur == CH_DOT) begin
                                dot_q <= 1'b1;
                            end else begin
                                neg_q <= 1'b1;
                            end
                        end else begin
                            term_q  <= cur;
                            state_q <= S_SCALE;
                        end
                    end
                    S_SCALE: if (scale_more) begin
                        acc_q  <= VAL_W'(acc_mul);
                        frac_q <= frac_q + FRAC_W'(1);
                    end else begin
                        case (key_q)
                            KEY_T:   begin t_sh_q <= val_c; t_seen_q <= 1'b1; end
                            KEY_L:   begin l_sh_q <= val_c; l_seen_q <= 1'b1; end
                            KEY_R:   begin r_sh_q <= val_c; r_seen_q <= 1'b1; end
                            default: ;
                        endcase
                        state_q <= (term_q == CH_COMMA) ? S_KEY_OPEN : S_WAIT_NL;
                    end
                    S_WAIT_NL: if (take && (cur == CH_LF)) state_q <= S_COMMIT;
                    S_COMMIT: begin
                        t_code_q    <= t_sh_q;
                        if (l_seen_q) l_val_q <= l_sh_q;
                        if (r_seen_q) r_val_q <= r_sh_q;
                        l_present_q <= l_seen_q;
                        r_present_q <= r_seen_q;
                        msg_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    S_ERROR: if (take && (cur == CH_LF)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef JSON_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                               err_cnt_q <= '0;
        else if (abort && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`endif

    assign msg_valid   = msg_valid_q;
    assign t_code      = t_code_q;
    assign l_val       = l_val_q;
    assign r_val       = r_val_q;
    assign l_present   = l_present_q;
    assign r_present   = r_present_q;
    assign parse_error = parse_error_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_json_feedback_rx.sv
// Directed bench for json_feedback_rx: serial frames in, scoreboard of committed outputs.
module tb_json_feedback_rx;
    localparam int unsigned CPB = 6;
    localparam int unsigned VW  = 32;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          uart_in = 1'b1;
    logic          msg_valid, l_present, r_present, parse_error, busy;
    logic [VW-1:0] t_code, l_val, r_val;
`ifdef JSON_RX_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    typedef struct {
        logic [VW-1:0] t;
        logic [VW-1:0] l;
        logic [VW-1:0] r;
        logic          lp;
        logic          rp;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     msg_cnt  = 0;
    int     err_cnt  = 0;
    longint cyc      = 0;
    longint lf_cyc   = -100;

    always #5 clk = ~clk;

    json_feedback_rx #(
        .CLKS_PER_BIT(CPB), .BITS_N(8), .VAL_W(VW), .FRAC_DIGITS(3), .MAX_VAL_CHARS(12)
    ) dut (
        .clk(clk), .rst(rst), .uart_in(uart_in), .msg_valid(msg_valid),
        .t_code(t_code), .l_val(l_val), .r_val(r_val),
        .l_present(l_present), .r_present(r_present),
        .parse_error(parse_error), .busy(busy)
`ifdef JSON_RX_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_exp(input int t, input int l, input int r, input logic lp, input logic rp);
        exp_t e;
        e.t = VW'(t); e.l = VW'(l); e.r = VW'(r); e.lp = lp; e.rp = rp;
        sb.push_back(e);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", VW'(sb.size()), VW'(0));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on each commit pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.u_rx.valid && dut.u_rx.data_rx == 8'h0A) lf_cyc = cyc;
            if (parse_error) err_cnt++;
            if (msg_valid) begin
                msg_cnt++;
                check("lf_to_msg_latency", VW'(cyc - lf_cyc), VW'(2));
                check("msg_expected", VW'(sb.size() != 0), VW'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("t_code", t_code, e.t);
                    check("l_val", l_val, e.l);
                    check("r_val", r_val, e.r);
                    check("l_present", VW'(l_present), VW'(e.lp));
                    check("r_present", VW'(r_present), VW'(e.rp));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0, e0;
        repeat (4) @(negedge clk);
        check("rst_msg_valid", VW'(msg_valid), VW'(0));
        check("rst_t_code", t_code, VW'(0));
        check("rst_l_val", l_val, VW'(0));
        check("rst_r_val", r_val, VW'(0));
        check("rst_present", VW'({l_present, r_present}), VW'(0));
        check("rst_parse_error", VW'(parse_error), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Negative fractions
        m0 = msg_cnt; e0 = err_cnt;
        push_exp(1, -500, -500, 1'b1, 1'b1);
        send_str("{\"T\":1,");
        check("busy_mid_frame", VW'(busy), VW'(1));
        send_str("\"L\":-0.5,\"R\":-0.5}\n");
        settle();
        check("f1_msgs", VW'(msg_cnt - m0), VW'(1));
        check("f1_errs", VW'(err_cnt - e0), VW'(0));
        check("busy_after_commit", VW'(busy), VW'(0));

        // Integer L/R scaled up, trailing extra newline ignored
        m0 = msg_cnt; e0 = err_cnt;
        push_exp(1001, 164000, 164000, 1'b1, 1'b1);
        send_str("{\"T\":1001,\"L\":164,\"R\":164}\n\n");
        settle();
        check("f2_msgs", VW'(msg_cnt - m0), VW'(1));
        check("f2_errs", VW'(err_cnt - e0), VW'(0));

        // Non-numeric value, then a good frame
        m0 = msg_cnt; e0 = err_cnt;
        send_str("{\"T\":x}\n");
        settle();
        check("bad_x_errs", VW'(err_cnt - e0), VW'(1));
        check("bad_x_msgs", VW'(msg_cnt - m0), VW'(0));
        check("bad_x_hold_t", t_code, VW'(1001));
        check("bad_x_hold_l", l_val, VW'(164000));
        push_exp(1, -500, -500, 1'b1, 1'b1);
        send_str("{\"T\":1,\"L\":-0.5,\"R\":-0.5}\n");
        settle();
        check("f3_msgs", VW'(msg_cnt - m0), VW'(1));

        // Truncated fraction, absent R keeps value; then magnitude overflow
        m0 = msg_cnt; e0 = err_cnt;
        push_exp(2, 123, -500, 1'b1, 1'b0);
        send_str("{\"T\":2,\"L\":0.12345}\n");
        settle();
        send_str("{\"T\":2,\"L\":99999999999}\n");
        settle();
        check("ovf_errs", VW'(err_cnt - e0), VW'(1));
        check("ovf_msgs", VW'(msg_cnt - m0), VW'(1));
        check("ovf_hold_l", l_val, VW'(123));

        // Reset mid-frame discards it
        send_str("{\"T\":5");
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", VW'(busy), VW'(0));
        check("midrst_t_code", t_code, VW'(0));
        m0 = msg_cnt; e0 = err_cnt;
        push_exp(7, 0, 0, 1'b0, 1'b0);
        send_str("{\"T\":7}\n");
        settle();
        check("f7_msgs", VW'(msg_cnt - m0), VW'(1));
        check("f7_errs", VW'(err_cnt - e0), VW'(0));

        // Missing T
        m0 = msg_cnt; e0 = err_cnt;
        send_str("{\"L\":1}\n");
        settle();
        check("noT_errs", VW'(err_cnt - e0), VW'(1));
        check("noT_msgs", VW'(msg_cnt - m0), VW'(0));

        // Whitespace, CR, unknown key, duplicate key
        m0 = msg_cnt; e0 = err_cnt;
        push_exp(3, 0, -12500, 1'b0, 1'b1);
        send_str("{ \"T\":3, \"R\":-12.5}\015\n");
        settle();
        push_exp(9, 0, -12500, 1'b0, 1'b0);
        send_str("{\"X\":5,\"T\":4,\"T\":9}\n");
        settle();
        check("ws_dup_msgs", VW'(msg_cnt - m0), VW'(2));

        // Multi-char key
        e0 = err_cnt;
        send_str("{\"TT\":1}\n");
        settle();
        check("longkey_errs", VW'(err_cnt - e0), VW'(1));
        check("longkey_hold_t", t_code, VW'(9));
        check("total_errs", VW'(err_cnt), VW'(4));

`ifdef JSON_RX_ERRCNT_EN
        check("errcnt_value", VW'(err_count), VW'(4));
        e0 = err_cnt;
        for (int i = 0; i < 300; i++) send_str("{\n");
        repeat (20) @(negedge clk);
        check("errcnt_pulses", VW'(err_cnt - e0), VW'(300));
        check("errcnt_saturated", VW'(err_count), VW'(255));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
